// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator driving the data cache strobe interface.
// Optional alignment/range faulting is enabled by defining MAU_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int N          = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic         req_byte,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  output logic [N-1:0] resp_rdata,
  output logic         resp_fault,
  output logic         stall,
  output logic [N-1:0] data_address,
  output logic [N-1:0] in_data,
  input  logic [N-1:0] out_data,
  output logic         read_enable,
  output logic         write_enable,
  output logic         isByte
);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, WAIT, DONE
  } state_t;

`ifdef MAU_ALIGN_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [ADDR_WIDTH-1:0] ADDR_TOP =
    {ADDR_WIDTH{1'b1}} - ADDR_WIDTH'(3);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         wr_q, wr_d;
  logic         req_ready_q, req_ready_d;
  logic         resp_valid_q, resp_valid_d;
  logic [N-1:0] resp_rdata_q, resp_rdata_d;
  logic         resp_fault_q, resp_fault_d;
  logic         stall_q, stall_d;
  logic [N-1:0] data_address_q, data_address_d;
  logic [N-1:0] in_data_q, in_data_d;
  logic         read_enable_q, read_enable_d;
  logic         write_enable_q, write_enable_d;
  logic         is_byte_q, is_byte_d;
  logic         fault;

  // Word accesses that are misaligned or would wrap past the top of memory.
  assign fault = CHK_EN & ~req_byte &
    ((req_addr[1:0] != 2'b00) |
     (req_addr[ADDR_WIDTH-1:0] > ADDR_TOP));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    data_address_d = data_address_q;
    in_data_d      = in_data_q;
    is_byte_d      = is_byte_q;
    resp_valid_d   = 1'b0;
    resp_rdata_d   = '0;
    resp_fault_d   = 1'b0;
    read_enable_d  = 1'b0;
    write_enable_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (fault) begin
            state_d      = DONE;
            resp_valid_d = 1'b1;
            resp_fault_d = 1'b1;
          end else begin
            state_d        = SETUP;
            wr_d           = req_write;
            is_byte_d      = req_byte;
            data_address_d = req_addr;
            in_data_d      = req_byte ?
              {{(N-8){1'b0}}, req_wdata[7:0]} : req_wdata;
          end
        end
      end
      SETUP: begin
        state_d        = STROBE;
        read_enable_d  = ~wr_q;
        write_enable_d = wr_q;
      end
      STROBE: begin
        state_d = WAIT;
        cnt_d   = LAT_M1;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d        = DONE;
          resp_valid_d   = 1'b1;
          data_address_d = '0;
          in_data_d      = '0;
          is_byte_d      = 1'b0;
          // Only the low byte is trusted on byte reads.
          if (!wr_q)
            resp_rdata_d = is_byte_q ?
              {{(N-8){1'b0}}, out_data[7:0]} : out_data;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    stall_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      wr_q           <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_fault_q   <= 1'b0;
      stall_q        <= 1'b0;
      data_address_q <= '0;
      in_data_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      is_byte_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_q           <= wr_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_fault_q   <= resp_fault_d;
      stall_q        <= stall_d;
      data_address_q <= data_address_d;
      in_data_q      <= in_data_d;
      read_enable_q  <= read_enable_d;
      write_enable_q <= write_enable_d;
      is_byte_q      <= is_byte_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_fault   = resp_fault_q;
  assign stall        = stall_q;
  assign data_address = data_address_q;
  assign in_data      = in_data_q;
  assign read_enable  = read_enable_q;
  assign write_enable = write_enable_q;
  assign isByte       = is_byte_q;

endmodule
